// File: rtl/soc_pkg.sv
// Shared SoC bus-select types, UART register map and UART FSM state types.
package soc_pkg;

    typedef enum logic {INTERNAL = 1'b0, EXTERNAL = 1'b1} e_chip_sel;
    typedef enum logic [1:0] {DRAM = 2'd0, IRAM = 2'd1, UART = 2'd2} e_block_sel;

    localparam logic [3:0] UART_DATA_OFS   = 4'h0;
    localparam logic [3:0] UART_STATUS_OFS = 4'h4;
    localparam logic [3:0] UART_DIV_OFS    = 4'h8;

    localparam int STAT_TX_BUSY    = 0;
    localparam int STAT_TX_FULL    = 1;
    localparam int STAT_RX_VALID   = 2;
    localparam int STAT_OVERFLOW   = 3;
    localparam int STAT_RX_OVERRUN = 4;
    localparam int STAT_LEVEL_LSB  = 8;

    localparam logic [15:0] UART_DIV_MIN = 16'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} e_tx_state;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} e_rx_state;

    function automatic logic [15:0] div_clamp(input logic [15:0] v);
        return (v < UART_DIV_MIN) ? UART_DIV_MIN : v;
    endfunction

endpackage

// File: rtl/soc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module soc_sync_fifo
    import soc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign level   = count;
    assign rdata   = mem[rptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/soc_uart.sv
// OBI slave UART: TX FIFO + 8N1 serialiser, DATA/STATUS/DIV registers.
// Optional 8N1 receiver is built when UART_RX_EN is defined.
//
// TX state | meaning
// TX_IDLE  | line high, waiting for a FIFO entry
// TX_START | start bit (0) for DIV cycles
// TX_DATA  | 8 data bits, LSB first, DIV cycles each
// TX_STOP  | stop bit (1); chains straight into TX_START if FIFO non-empty
//
// RX state | meaning
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | half-bit wait, then re-check start bit
// RX_DATA  | sample 8 data bits every DIV cycles
// RX_STOP  | sample stop bit; deliver byte only if it is 1
module soc_uart
    import soc_pkg::*;
#(
    parameter int CLK_FREQ        = 25_000_000,
    parameter int BAUDRATE        = 115200,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        obi_req_i,
    output logic        obi_gnt_o,
    input  logic [3:0]  obi_addr_i,
    input  logic        obi_we_i,
    input  logic [3:0]  obi_be_i,
    input  logic [31:0] obi_wdata_i,
    output logic        obi_rvalid_o,
    output logic [31:0] obi_rdata_o,
    output logic        ser_tx_o,
    input  logic        ser_rx_i
);

    localparam logic [15:0] DIV_RST = div_clamp(16'(CLK_FREQ / BAUDRATE));

    logic        wr, rd, is_data, is_status, is_div;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [FIFO_DEPTH_LOG2:0] fifo_level;
    logic [15:0] div_q, div_new;
    logic        overflow_q;
    logic [31:0] status, rd_val;
    logic        rx_valid, rx_overrun;
    logic [7:0]  rx_byte;

    e_tx_state   tx_state;
    logic [15:0] tx_cnt;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_bit;

    assign obi_gnt_o = obi_req_i;
    assign wr        = obi_req_i & obi_we_i;
    assign rd        = obi_req_i & ~obi_we_i;
    assign is_data   = (obi_addr_i == UART_DATA_OFS);
    assign is_status = (obi_addr_i == UART_STATUS_OFS);
    assign is_div    = (obi_addr_i == UART_DIV_OFS);
    assign fifo_push = wr & is_data & obi_be_i[0];
    assign fifo_pop  = ~fifo_empty &
                       ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & (tx_cnt == '0)));

    soc_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (obi_wdata_i[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        div_new = div_q;
        if (obi_be_i[0]) div_new[7:0]  = obi_wdata_i[7:0];
        if (obi_be_i[1]) div_new[15:8] = obi_wdata_i[15:8];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q      <= DIV_RST;
            overflow_q <= 1'b0;
        end else begin
            if (wr && is_div) div_q <= div_clamp(div_new);
            if (wr && is_status && obi_wdata_i[STAT_OVERFLOW])
                overflow_q <= 1'b0;
            else if (fifo_push && fifo_full && !fifo_pop)
                overflow_q <= 1'b1;
        end
    end

    always_comb begin
        status                  = '0;
        status[STAT_TX_BUSY]    = ~fifo_empty | (tx_state != TX_IDLE);
        status[STAT_TX_FULL]    = fifo_full;
        status[STAT_RX_VALID]   = rx_valid;
        status[STAT_OVERFLOW]   = overflow_q;
        status[STAT_RX_OVERRUN] = rx_overrun;
        status[STAT_LEVEL_LSB +: FIFO_DEPTH_LOG2 + 1] = fifo_level;
    end

    always_comb begin
        rd_val = '0;
        if (rd) begin
            case (obi_addr_i)
                UART_DATA_OFS:   rd_val = {24'b0, rx_byte};
                UART_STATUS_OFS: rd_val = status;
                UART_DIV_OFS:    rd_val = {16'b0, div_q};
                default:         rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            obi_rvalid_o <= 1'b0;
            obi_rdata_o  <= '0;
        end else begin
            obi_rvalid_o <= obi_req_i;
            obi_rdata_o  <= rd_val;
        end
    end

    // Bit period is reloaded from div_q at every bit start, so a DIV write
    // never disturbs the bit already on the line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state <= TX_IDLE;
            ser_tx_o <= 1'b1;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    ser_tx_o <= 1'b1;
                    if (!fifo_empty) begin
                        tx_state <= TX_START;
                        ser_tx_o <= 1'b0;
                        tx_shift <= fifo_rdata;
                        tx_cnt   <= div_q - 16'd1;
                    end
                end
                TX_START: begin
                    if (tx_cnt == '0) begin
                        tx_state <= TX_DATA;
                        ser_tx_o <= tx_shift[0];
                        tx_bit   <= '0;
                        tx_cnt   <= div_q - 16'd1;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= div_q - 16'd1;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            ser_tx_o <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            ser_tx_o <= tx_shift[tx_bit + 3'd1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == '0) begin
                        if (!fifo_empty) begin
                            tx_state <= TX_START;
                            ser_tx_o <= 1'b0;
                            tx_shift <= fifo_rdata;
                            tx_cnt   <= div_q - 16'd1;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

`ifdef UART_RX_EN
    e_rx_state   rx_state;
    logic        rx_meta, rx_sync, rx_prev;
    logic [15:0] rx_cnt;
    logic [7:0]  rx_shift;
    logic [2:0]  rx_bit;
    logic        rx_clear;

    assign rx_clear = rd & is_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= ser_rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_shift   <= '0;
            rx_bit     <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_clear) rx_valid <= 1'b0;
            if (wr && is_status && obi_wdata_i[STAT_RX_OVERRUN]) rx_overrun <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= {1'b0, div_q[15:1]} - 16'd1;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                        rx_cnt   <= div_q - 16'd1;
                        rx_bit   <= '0;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_cnt   <= div_q - 16'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == '0) begin
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_byte  <= rx_shift;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rx_clear) rx_overrun <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
`else
    logic unused_rx;
    assign unused_rx  = ser_rx_i;
    assign rx_valid   = 1'b0;
    assign rx_overrun = 1'b0;
    assign rx_byte    = 8'h00;
`endif

    logic unused_bits;
    assign unused_bits = ^{obi_wdata_i[31:16], obi_be_i[3:2]};

endmodule
